fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

- Shares the single write port of the team's 1024-entry, 8-bit FIFO among N independent producers.
- Arbitration is round-robin at burst granularity: a granted producer keeps the port until it signals last or hits a beat limit.
- Honours FIFO `full` back-pressure so no write is ever issued into a full FIFO.
- Sits directly in front of the FIFO; the FIFO read side is untouched.

## Interface
Parameters:
- `N_REQ`, 4: number of producers (2..8).
- `DATA_W`, 8: beat width; must match the FIFO `din` width.
- `MAX_BURST`, 16: maximum beats per grant (1..255).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  N_REQ  — per-producer beat valid.
- `req_last`  in  N_REQ  — per-producer end-of-burst marker, qualified by valid.
- `req_data`  in  N_REQ*DATA_W  — packed beats; producer i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  N_REQ  — per-producer accept.
- `fifo_full`  in  1  — FIFO full flag.
- `fifo_wr_en`  out  1  — FIFO write enable.
- `fifo_din`  out  DATA_W  — FIFO write data.
- `grant_id`  out  $clog2(N_REQ)  — index of the current owner.
- `busy`  out  1  — high while in GRANT.

## Operation
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If any `req_valid` is high, select the first requester at or after `rr_ptr`, searching upward with wrap-around.
  - Register the selection into `grant_id`, clear `beat_cnt`, go to GRANT.
  - If no request, stay in IDLE.
- GRANT, with `g = grant_id`:
  - `req_ready[g] = !fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wr_en = req_valid[g] && !fifo_full`; `fifo_din = req_data[g]`. Both are combinational from registered state.
  - A beat transfers when `req_valid[g] && req_ready[g]`; `beat_cnt` then increments.
  - The burst ends on a transfer with `req_last[g]` high, or on a transfer that makes `beat_cnt == MAX_BURST`.
  - At burst end: `rr_ptr <= g+1` (wrapping at N_REQ-1 → 0), go to IDLE.
- Grant is locked: if the owner drops `req_valid` mid-burst, the grant holds, and no other producer is served until the burst ends.
- Non-granted producers see `req_ready = 0` and must hold their data.
- `beat_cnt` is 8 bits wide and never exceeds `MAX_BURST`.

## Timing
- Reset values:
  - state = IDLE; `rr_ptr` = 0; `grant_id` = 0; `beat_cnt` = 0.
  - `busy` = 0; `req_ready` = 0; `fifo_wr_en` = 0; `fifo_din` = 0.
- Arbitration latency: a request seen in IDLE at edge k is granted from cycle k+1; the first beat can write at edge k+1 if `fifo_full` is low.
- Throughput: one beat per cycle in GRANT, plus one idle cycle per burst for arbitration.
- `fifo_full` high freezes the transfer: no write, no `beat_cnt` change, state held.
  - `fifo_full` is sampled in the same cycle; the FIFO counts the write at that same edge.
- `req_last` on the first beat gives a 1-beat burst.
- `MAX_BURST` reached without `req_last`: the burst is forcibly ended. The producer's remaining beats re-arbitrate later.
- Reset mid-burst: immediate return to reset values. The partially written burst stays in the FIFO.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds output `beat_count` (N_REQ*16): one 16-bit saturating counter per producer, incremented on each transfer by that producer.
  - Adds output `stall_count` (16): saturating count of GRANT cycles with `req_valid[g] && fifo_full`.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist; the remaining behaviour is identical.

## Structure
- Package `fifo_arb_pkg` holds:
  - state enum `arb_state_e {ARB_IDLE, ARB_GRANT}`;
  - constant `ARB_CNT_W = 16`;
  - function `rr_pick(req, ptr)` returning the next index.
- One sub-module, `rr_picker`: combinational round-robin priority selection, returning index and found flag. It is reusable by the read-side scheduler.

## Test plan
- Single producer 0, 3 beats 0xA1, 0xA2, 0xA3 with last on 0xA3 → grant at cycle 1; writes on 3 consecutive cycles; `busy` drops; `rr_ptr` = 1.
- Producers 0–3 all valid, 2-beat bursts each → grant order 0, 1, 2, 3, 0; one idle cycle between bursts.
- MAX_BURST = 4, producer 2 sends 6 beats with last on beat 6 → 4 writes, regrant to another waiting producer, then producer 2's last 2 beats.
- `fifo_full` asserted for 3 cycles mid-burst → `fifo_wr_en` = 0 and `req_ready` = 0 for those cycles; no beat lost or duplicated; order preserved.
- `rst` pulsed low during beat 2 of a burst → all outputs return to reset values; next grant starts at producer 0.
- With `FIFO_ARB_STATS_EN`, 70000 beats from producer 1 → its `beat_count` saturates at 0xFFFF; the other counters stay 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for FIFO-side schedulers: FSM state encoding,
// statistics counter width and the round-robin pick function.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_CNT_W  = 16;
  localparam int RR_MAX_REQ = 8;
  localparam int RR_IDX_W   = 3;

  // Unused upper request bits are tied to zero by callers, so wrapping the
  // search at RR_MAX_REQ selects the same index as wrapping at the real count.
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                                  input logic [RR_IDX_W-1:0]   ptr);
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < RR_MAX_REQ; i++) begin
      idx = ptr + RR_IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr_i,
// searching upward with wrap-around. Shared with the read-side scheduler.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [RR_MAX_REQ-1:0] req_pad;
  logic [RR_IDX_W-1:0]   ptr_pad;
  logic [RR_IDX_W-1:0]   pick;

  assign req_pad = RR_MAX_REQ'(req_i);
  assign ptr_pad = RR_IDX_W'(ptr_i);
  assign pick    = rr_pick(req_pad, ptr_pad);
  assign idx_o   = IDX_W'(pick);
  assign found_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-granular round-robin arbiter sharing one FIFO write port among N_REQ
// producers. Define FIFO_ARB_STATS_EN to add per-producer beat and stall counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 16,
  localparam int GID_W     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_din,
  output logic [GID_W-1:0]        grant_id,
  output logic                    busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*ARB_CNT_W-1:0] beat_count,
  output logic [ARB_CNT_W-1:0]       stall_count
`endif
);

  arb_state_e       state_q, state_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]       beat_cnt_inc;
  logic [GID_W-1:0] pick_idx;
  logic             pick_found;
  logic             xfer;
  logic             burst_end;

  rr_picker #(.N(N_REQ)) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign busy         = (state_q == ARB_GRANT);
  assign grant_id     = grant_id_q;
  assign xfer         = busy && req_valid[grant_id_q] && !fifo_full;
  assign beat_cnt_inc = beat_cnt_q + 8'd1;
  assign burst_end    = xfer && (req_last[grant_id_q] || beat_cnt_inc == 8'(MAX_BURST));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_GRANT;
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (xfer) beat_cnt_d = beat_cnt_inc;
        if (burst_end) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_id_q == GID_W'(N_REQ - 1)) ? '0 : grant_id_q + GID_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // The grant is locked to grant_id_q; full back-pressure gates both the
  // accept and the write in the same cycle the FIFO reports it.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (busy) begin
      req_ready[grant_id_q] = !fifo_full;
      fifo_wr_en            = xfer;
      fifo_din              = req_data[grant_id_q*DATA_W +: DATA_W];
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [N_REQ-1:0][ARB_CNT_W-1:0] beat_stat_q;
  logic [ARB_CNT_W-1:0]            stall_stat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_stat_q  <= '0;
      stall_stat_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (xfer && grant_id_q == GID_W'(i) && beat_stat_q[i] != '1)
          beat_stat_q[i] <= beat_stat_q[i] + ARB_CNT_W'(1);
      end
      if (busy && req_valid[grant_id_q] && fifo_full && stall_stat_q != '1)
        stall_stat_q <= stall_stat_q + ARB_CNT_W'(1);
    end
  end

  assign beat_count  = beat_stat_q;
  assign stall_count = stall_stat_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (MAX_BURST = 4); the statistics section
// runs only when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic [1:0]    grant_id;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Producer beat stores: data, last flag, head index and fill count.
  logic [7:0] pd [N][16];
  logic       pl [N][16];
  int         ph [N];
  int         pn [N];

  int         t2_g [16] = '{-1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0, 0, -1, 1, 1, -1};
  logic [7:0] t2_d [16] = '{8'h00, 8'h20, 8'h21, 8'h00, 8'h30, 8'h31, 8'h00, 8'h40,
                            8'h41, 8'h00, 8'h10, 8'h11, 8'h00, 8'h22, 8'h23, 8'h00};
  int         t3_g [11] = '{-1, 2, 2, 2, 2, -1, 3, -1, 2, 2, -1};
  logic [7:0] t3_d [11] = '{8'h00, 8'h50, 8'h51, 8'h52, 8'h53, 8'h00, 8'h60, 8'h00,
                            8'h54, 8'h55, 8'h00};
  int         t4_g [8]  = '{-1, 3, 3, 3, 3, 3, 3, -1};
  bit         t4_f [8]  = '{0, 0, 1, 1, 1, 0, 0, 0};
  bit         t4_w [8]  = '{0, 1, 0, 0, 0, 1, 1, 0};
  logic [7:0] t4_d [8]  = '{8'h00, 8'h70, 8'h00, 8'h00, 8'h00, 8'h71, 8'h72, 8'h00};

`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] beat_count;
  logic [15:0]     stall_count;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic            s_wr_en;
  logic [DW-1:0]   s_din;
  logic [1:0]      s_grant;
  logic            s_busy;
  logic [N*16-1:0] s_beat_count;
  logic [15:0]     s_stall_count;
`endif

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_count (beat_count),
    .stall_count(stall_count)
`endif
  );

`ifdef FIFO_ARB_STATS_EN
  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(255)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (s_valid),
    .req_last   (4'b0000),
    .req_data   (32'h5A5A5A5A),
    .req_ready  (s_ready),
    .fifo_full  (1'b0),
    .fifo_wr_en (s_wr_en),
    .fifo_din   (s_din),
    .grant_id   (s_grant),
    .busy       (s_busy),
    .beat_count (s_beat_count),
    .stall_count(s_stall_count)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(int p, logic [7:0] d, bit l);
    pd[p][pn[p]] = d;
    pl[p][pn[p]] = l;
    pn[p]++;
  endtask

  // Present each producer's head beat on the falling edge, settle, return.
  task automatic drive(bit full);
    @(negedge clk);
    fifo_full = full;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = (ph[i] < pn[i]);
      req_last[i]           = req_valid[i] ? pl[i][ph[i]] : 1'b0;
      req_data[i*DW +: DW]  = req_valid[i] ? pd[i][ph[i]] : 8'h00;
    end
    #1;
  endtask

  // A producer retires its head beat when the arbiter accepted it.
  task automatic advance();
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) ph[i]++;
  endtask

  // gid_e < 0 means the arbiter is expected to be in IDLE this cycle.
  task automatic exp_cyc(string tag, int gid_e, bit wr_e, logic [7:0] din_e);
    logic [N-1:0] rdy_e;
    rdy_e = '0;
    if (gid_e >= 0 && !fifo_full) rdy_e[gid_e] = 1'b1;
    check({tag, ".busy"},  32'(busy),       32'(gid_e >= 0));
    check({tag, ".ready"}, 32'(req_ready),  32'(rdy_e));
    check({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(wr_e));
    if (gid_e >= 0) check({tag, ".gid"}, 32'(grant_id), 32'(gid_e));
    if (wr_e)       check({tag, ".din"}, 32'(fifo_din), 32'(din_e));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, ".busy"},  32'(busy),       32'h0);
    check({tag, ".ready"}, 32'(req_ready),  32'h0);
    check({tag, ".wr_en"}, 32'(fifo_wr_en), 32'h0);
    check({tag, ".din"},   32'(fifo_din),   32'h0);
    check({tag, ".gid"},   32'(grant_id),   32'h0);
  endtask

  initial begin
    rst       = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      ph[i] = 0;
      pn[i] = 0;
    end
`ifdef FIFO_ARB_STATS_EN
    s_valid = '0;
`endif

    drive(1'b0);
    check_reset_outputs("reset");
    #1 rst = 1'b1;

    // Single producer, three beats: grant one cycle after the request.
    load(0, 8'hA1, 1'b0);
    load(0, 8'hA2, 1'b0);
    load(0, 8'hA3, 1'b1);
    drive(1'b0); exp_cyc("t1_c0", -1, 1'b0, 8'h00); advance();
    drive(1'b0); exp_cyc("t1_c1",  0, 1'b1, 8'hA1); advance();
    drive(1'b0); exp_cyc("t1_c2",  0, 1'b1, 8'hA2); advance();
    drive(1'b0); exp_cyc("t1_c3",  0, 1'b1, 8'hA3); advance();
    drive(1'b0); exp_cyc("t1_c4", -1, 1'b0, 8'h00); advance();

    // All producers busy with 2-beat bursts; rr_ptr is 1 after the first burst.
    for (int i = 0; i < N; i++) begin
      load(i, 8'(8'h10 * (i + 1)), 1'b0);
      load(i, 8'(8'h10 * (i + 1) + 1), 1'b1);
    end
    load(1, 8'h22, 1'b0);
    load(1, 8'h23, 1'b1);
    for (int c = 0; c < 16; c++) begin
      drive(1'b0);
      exp_cyc($sformatf("t2_c%0d", c), t2_g[c], t2_g[c] >= 0, t2_d[c]);
      advance();
    end

    // Producer 2 exceeds MAX_BURST while producer 3 waits.
    for (int b = 0; b < 6; b++) load(2, 8'(8'h50 + b), b == 5);
    load(3, 8'h60, 1'b1);
    for (int c = 0; c < 11; c++) begin
      drive(1'b0);
      exp_cyc($sformatf("t3_c%0d", c), t3_g[c], t3_g[c] >= 0, t3_d[c]);
      advance();
    end

    // Three cycles of FIFO full in the middle of a burst.
    load(3, 8'h70, 1'b0);
    load(3, 8'h71, 1'b0);
    load(3, 8'h72, 1'b1);
    for (int c = 0; c < 8; c++) begin
      drive(t4_f[c]);
      exp_cyc($sformatf("t4_c%0d", c), t4_g[c], t4_w[c], t4_d[c]);
      advance();
    end

`ifdef FIFO_ARB_STATS_EN
    check("stats.p0",    32'(beat_count[0*16 +: 16]), 32'd5);
    check("stats.p1",    32'(beat_count[1*16 +: 16]), 32'd4);
    check("stats.p2",    32'(beat_count[2*16 +: 16]), 32'd8);
    check("stats.p3",    32'(beat_count[3*16 +: 16]), 32'd6);
    check("stats.stall", 32'(stall_count),            32'd3);
`endif

    // Reset during beat 2 of producer 2's burst, with rr_ptr at 2.
    load(1, 8'h90, 1'b1);
    load(2, 8'h80, 1'b0);
    load(2, 8'h81, 1'b0);
    load(2, 8'h82, 1'b1);
    drive(1'b0); exp_cyc("t5_c0", -1, 1'b0, 8'h00); advance();
    drive(1'b0); exp_cyc("t5_c1",  1, 1'b1, 8'h90); advance();
    drive(1'b0); exp_cyc("t5_c2", -1, 1'b0, 8'h00); advance();
    drive(1'b0); exp_cyc("t5_c3",  2, 1'b1, 8'h80); advance();
    drive(1'b0); exp_cyc("t5_c4",  2, 1'b1, 8'h81);
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    advance();
    load(0, 8'hA0, 1'b1);
    drive(1'b0);
    check("t5_rst_hold.busy",  32'(busy),      32'h0);
    check("t5_rst_hold.ready", 32'(req_ready), 32'h0);
    #1 rst = 1'b1;
    drive(1'b0); exp_cyc("t5_c6",  0, 1'b1, 8'hA0); advance();
    drive(1'b0); exp_cyc("t5_c7", -1, 1'b0, 8'h00); advance();
    drive(1'b0); exp_cyc("t5_c8",  2, 1'b1, 8'h81); advance();
    drive(1'b0); exp_cyc("t5_c9",  2, 1'b1, 8'h82); advance();
    drive(1'b0); exp_cyc("t5_c10", -1, 1'b0, 8'h00); advance();

`ifdef FIFO_ARB_STATS_EN
    // 70400 cycles of 255-beat bursts from producer 1 give 70125 beats.
    @(negedge clk);
    s_valid = 4'b0010;
    repeat (70400) @(negedge clk);
    s_valid = '0;
    @(negedge clk);
    #1;
    check("sat.p0",    32'(s_beat_count[0*16 +: 16]), 32'h0);
    check("sat.p1",    32'(s_beat_count[1*16 +: 16]), 32'hFFFF);
    check("sat.p2",    32'(s_beat_count[2*16 +: 16]), 32'h0);
    check("sat.p3",    32'(s_beat_count[3*16 +: 16]), 32'h0);
    check("sat.stall", 32'(s_stall_count),            32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
